// File: rtl/vga_console_writer_pkg.sv
// vga_console_writer_pkg: geometry, control codes, video-word layout and FSM states for the console writer
package vga_console_writer_pkg;
    localparam int COLS = 39;
    localparam int ROWS = 13;
    localparam logic [6:0] BLANK = 7'h20;
    localparam logic [8:0] CLR_COLOR = 9'h1FF;
    localparam logic [6:0] CH_LF = 7'h0A;
    localparam logic [6:0] CH_CR = 7'h0D;
    localparam logic [6:0] CH_BS = 7'h08;
    localparam logic [6:0] CH_FF = 7'h0C;
    localparam logic [6:0] CURSOR_GLYPH = 7'h5F;
    localparam logic [8:0] LAST_ADDR = 9'(ROWS * COLS - 1);
    localparam logic [8:0] LINE_LAST = 9'(COLS - 1);
    localparam logic [5:0] EOL_COL = 6'(COLS - 1);
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    // video word: rgb in [15:7], char in [6:0]
    function automatic logic [15:0] video_word(input logic [8:0] rgb, input logic [6:0] ch);
        return {rgb, ch};
    endfunction

    localparam logic [15:0] BLANK_WORD = {CLR_COLOR, BLANK};

    typedef enum logic [1:0] {
        S_CLR_ALL,
        S_IDLE,
        S_CLR_LINE
`ifdef VGA_CONSOLE_CURSOR_EN
        , S_CUR_DRAW
`endif
    } state_t;
endpackage

// File: rtl/vga_cursor_ctr.sv
// vga_cursor_ctr: cursor row/col plus running row base (row*COLS) so the linear address needs no multiplier
module vga_cursor_ctr
    import vga_console_writer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    input  logic       nl,
    input  logic       cr,
    input  logic       home,
    input  logic       bs,
    output logic [3:0] row,
    output logic [5:0] col,
    output logic [8:0] base,
    output logic [8:0] addr
);
    logic wrap_row;

    assign wrap_row = row == LAST_ROW;
    assign addr = base + 9'(col);

    always_ff @(posedge clk) begin
        if (rst || home) begin
            row <= '0;
            col <= '0;
            base <= '0;
        end else if (nl || (adv && col == EOL_COL)) begin
            col <= '0;
            row <= wrap_row ? '0 : row + 4'd1;
            base <= wrap_row ? '0 : base + 9'(COLS);
        end else if (adv) begin
            col <= col + 6'd1;
        end else if (cr) begin
            col <= '0;
        end else if (bs && col != '0) begin
            col <= col - 6'd1;
        end
    end
endmodule

// File: rtl/vga_console_writer.sv
// vga_console_writer: ASCII/control byte stream to registered video-memory writes with cursor and clears
// Optional visible cursor glyph when VGA_CONSOLE_CURSOR_EN is defined.
module vga_console_writer
    import vga_console_writer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ch_valid,
    output logic        ch_ready,
    input  logic [6:0]  ch_data,
    input  logic [8:0]  ch_color,
    output logic        we,
    output logic [8:0]  mem_addr,
    output logic [15:0] mem_data,
    output logic [3:0]  cur_row,
    output logic [5:0]  cur_col
);
`ifdef VGA_CONSOLE_CURSOR_EN
    localparam logic CURSOR_EN = 1'b1;
    localparam state_t S_MOVED = S_CUR_DRAW;
`else
    localparam logic CURSOR_EN = 1'b0;
    localparam state_t S_MOVED = S_IDLE;
`endif

    state_t state, state_n;
    logic [8:0] cnt, cnt_n, row_base, cur_addr, addr_n;
    logic [15:0] data_n;
    logic we_n, adv, nl, cr, home, bs, printable;

    assign printable = ch_data >= BLANK && ch_data <= 7'h7E;

    vga_cursor_ctr u_cursor (
        .clk  (clk),
        .rst  (rst),
        .adv  (adv),
        .nl   (nl),
        .cr   (cr),
        .home (home),
        .bs   (bs),
        .row  (cur_row),
        .col  (cur_col),
        .base (row_base),
        .addr (cur_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLR_ALL;
            cnt <= '0;
            we <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            we <= we_n;
            mem_addr <= addr_n;
            mem_data <= data_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        we_n = 1'b0;
        addr_n = mem_addr;
        data_n = mem_data;
        adv = 1'b0;
        nl = 1'b0;
        cr = 1'b0;
        home = 1'b0;
        bs = 1'b0;
        ch_ready = 1'b0;
        case (state)
            S_CLR_ALL: begin
                we_n = 1'b1;
                addr_n = cnt;
                data_n = BLANK_WORD;
                cnt_n = (cnt == LAST_ADDR) ? '0 : cnt + 9'd1;
                state_n = (cnt == LAST_ADDR) ? S_MOVED : S_CLR_ALL;
            end
            S_CLR_LINE: begin
                we_n = 1'b1;
                addr_n = row_base + cnt;
                data_n = BLANK_WORD;
                cnt_n = (cnt == LINE_LAST) ? '0 : cnt + 9'd1;
                state_n = (cnt == LINE_LAST) ? S_MOVED : S_CLR_LINE;
            end
`ifdef VGA_CONSOLE_CURSOR_EN
            S_CUR_DRAW: begin
                we_n = 1'b1;
                addr_n = cur_addr;
                data_n = video_word(CLR_COLOR, CURSOR_GLYPH);
                state_n = S_IDLE;
            end
`endif
            default: begin
                ch_ready = 1'b1;
                if (ch_valid) begin
                    if (printable) begin
                        we_n = 1'b1;
                        addr_n = cur_addr;
                        data_n = video_word(ch_color, ch_data);
                        adv = 1'b1;
                        state_n = (cur_col == EOL_COL) ? S_CLR_LINE : S_MOVED;
                    end else if (ch_data == CH_LF || ch_data == CH_CR) begin
                        // with a visible cursor the old glyph is erased before moving
                        we_n = CURSOR_EN;
                        addr_n = cur_addr;
                        data_n = BLANK_WORD;
                        nl = ch_data == CH_LF;
                        cr = ch_data == CH_CR;
                        state_n = (ch_data == CH_LF) ? S_CLR_LINE : S_MOVED;
                    end else if (ch_data == CH_BS && cur_col != '0) begin
                        we_n = 1'b1;
                        addr_n = CURSOR_EN ? cur_addr : cur_addr - 9'd1;
                        data_n = BLANK_WORD;
                        bs = 1'b1;
                        state_n = S_MOVED;
                    end else if (ch_data == CH_FF) begin
                        home = 1'b1;
                        state_n = S_CLR_ALL;
                    end
                end
            end
        endcase
    end
endmodule

// File: tb/tb_vga_console_writer.sv
// tb_vga_console_writer: random char stream checked against a screen-level write/cursor model
module tb_vga_console_writer;
    localparam int COLS = 39;
    localparam int ROWS = 13;
    localparam logic [15:0] BLANK_W = 16'hFFA0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ch_valid = 1'b0;
    logic [6:0] ch_data = '0;
    logic [8:0] ch_color = '0;
    logic ch_ready, we;
    logic [8:0] mem_addr;
    logic [15:0] mem_data;
    logic [3:0] cur_row;
    logic [5:0] cur_col;

    int vectors = 0;
    int errors = 0;
    int busy = 0;
    int m_row = 0;
    int m_col = 0;
    logic [24:0] exp_q[$];

    vga_console_writer dut (
        .clk      (clk),
        .rst      (rst),
        .ch_valid (ch_valid),
        .ch_ready (ch_ready),
        .ch_data  (ch_data),
        .ch_color (ch_color),
        .we       (we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .cur_row  (cur_row),
        .cur_col  (cur_col)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        logic [24:0] e;
        @(negedge clk);
        if (!ch_ready) busy++;
        if (we) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", 32'(we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("write", {7'd0, mem_addr, mem_data}, {7'd0, e});
            end
        end
    endtask

    function automatic void push(input int a, input logic [15:0] d);
        exp_q.push_back({9'(a), d});
    endfunction

    function automatic void newline();
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        for (int i = 0; i < COLS; i++) push(m_row * COLS + i, BLANK_W);
    endfunction

    function automatic void model(input logic [6:0] c, input logic [8:0] color);
        if (c >= 7'h20 && c <= 7'h7E) begin
            push(m_row * COLS + m_col, {color, c});
            if (m_col == COLS - 1) newline();
            else m_col++;
        end else if (c == 7'h0A) begin
            newline();
        end else if (c == 7'h0D) begin
            m_col = 0;
        end else if (c == 7'h08) begin
            if (m_col > 0) begin
                m_col--;
                push(m_row * COLS + m_col, BLANK_W);
            end
        end else if (c == 7'h0C) begin
            m_row = 0;
            m_col = 0;
            for (int i = 0; i < ROWS * COLS; i++) push(i, BLANK_W);
        end
    endfunction

    task automatic send(input logic [6:0] c, input logic [8:0] color);
        int n = 0;
        ch_data = c;
        ch_color = color;
        ch_valid = 1'b1;
        while (!ch_ready && n < 3000) begin
            tick();
            n++;
        end
        if (!ch_ready) begin
            check("ready_timeout", 32'(ch_ready), 32'd1);
            ch_valid = 1'b0;
            return;
        end
        model(c, color);
        tick();
        ch_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
        check("cur_row", 32'(cur_row), 32'(m_row));
        check("cur_col", 32'(cur_col), 32'(m_col));
    endtask

    function automatic logic [6:0] rnd_print();
        return 7'($urandom_range(32, 126));
    endfunction

    function automatic logic [6:0] rnd_char();
        int r = $urandom_range(0, 99);
        logic [6:0] c;
        if (r < 70) return rnd_print();
        if (r < 80) return 7'h0A;
        if (r < 87) return 7'h0D;
        if (r < 95) return 7'h08;
        if (r < 96) return 7'h0C;
        c = 7'($urandom_range(0, 31));
        return (c == 7'h08 || c == 7'h0A || c == 7'h0C || c == 7'h0D) ? 7'h7F : c;
    endfunction

    initial begin
        tick();
        check("rst_we", 32'(we), 32'd0);
        check("rst_ready", 32'(ch_ready), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'(mem_data), 32'd0);
        check("rst_row", 32'(cur_row), 32'd0);
        check("rst_col", 32'(cur_col), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < ROWS * COLS; i++) push(i, BLANK_W);
        drain();
        check("init_ready", 32'(ch_ready), 32'd1);

        send(7'h41, 9'h1C0);
        drain();

        for (int i = 0; i < 37; i++) send(rnd_print(), 9'($urandom));
        busy = 0;
        send(rnd_print(), 9'($urandom));
        drain();
        check("wrap_busy", 32'(busy), 32'd39);

        for (int i = 0; i < 11; i++) send(7'h0A, 9'd0);
        for (int i = 0; i < 5; i++) send(rnd_print(), 9'($urandom));
        drain();
        send(7'h0A, 9'd0);
        drain();

        send(7'h08, 9'd0);
        drain();
        send(7'h0A, 9'd0);
        for (int i = 0; i < 3; i++) send(rnd_print(), 9'($urandom));
        send(7'h08, 9'd0);
        drain();

        send(7'h0A, 9'd0);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        check("mid_rst_we", 32'(we), 32'd0);
        rst = 1'b0;
        m_row = 0;
        m_col = 0;
        for (int i = 0; i < ROWS * COLS; i++) push(i, BLANK_W);
        drain();

        for (int i = 0; i < 60; i++) send(rnd_print(), 9'($urandom));
        send(7'h0A, 9'd0);
        send(rnd_print(), 9'($urandom));
        send(7'h0C, 9'd0);
        drain();

        for (int i = 0; i < 300; i++) begin
            send(rnd_char(), 9'($urandom));
            if (i % 10 == 9) drain();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
